i2c_cmd_sequencer: RTL

Parametrised successor to the single-shot button-to-I2C trigger. It issues a table of I2C write/read commands to the existing `i2c_master`, one after another, with a programmable inter-command gap. A run starts on a debounced button press or, optionally, automatically once after reset. It also generates the bus-rate clock-enable tick for the master, replacing the divided `slow_clk`, so the whole design runs on `clk`.

---
 rtl/i2c_cmd_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Table-driven I2C command sequencer: bus-rate tick, debounced/auto launch,
// per-entry start handshake with timeout, programmable inter-command gap.
module i2c_cmd_sequencer #(
  parameter int NUM_CMDS       = 2,
  parameter int DATA_BYTES     = 2,
  parameter logic [NUM_CMDS*(11+8*DATA_BYTES)-1:0] CMD_TABLE =
    (NUM_CMDS*(11+8*DATA_BYTES))'({7'h58, 1'b1, 3'd2, 16'h0000,
                                    7'h58, 1'b0, 3'd2, 16'h3001}),
  parameter int CLK_DIV        = 62,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int GAP_TICKS      = 100,
  parameter int START_TIMEOUT  = 16,
  parameter int AUTO_START     = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    button,
  input  logic                    i2c_ready,
  output logic                    i2c_tick,
  output logic                    i2c_start,
  output logic [6:0]              i2c_addr,
  output logic                    i2c_rw,
  output logic [2:0]              i2c_packets,
  output logic [8*DATA_BYTES-1:0] i2c_data,
  output logic                    debounced,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [3:0]              cmd_index
);
  localparam int ENTRY_W = 11 + 8*DATA_BYTES;
  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_TICKS + 2);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS > 0 ? GAP_TICKS - 1 : 0);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_CMDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;
  state_t state, state_n;

  logic [CW-1:0]      div_cnt;
  logic               sync1, sync2, deb_q, auto_pend;
  logic [DW-1:0]      db_cnt;
  logic [TW-1:0]      to_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               launch, issue_ok, timeout, cmd_fin, last, gap_end, next_cmd;
  logic [3:0]         ld_idx;
  logic [ENTRY_W-1:0] ld_entry;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) div_cnt <= '0;
    else          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

  assign i2c_tick = (div_cnt == DIV_LAST);

  // db_cnt counts consecutive tick samples that disagree with debounced
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= 1'b0; sync2 <= 1'b0; deb_q <= 1'b0;
      debounced <= 1'b0; db_cnt <= '0; auto_pend <= (AUTO_START != 0);
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      deb_q <= debounced;
      if (i2c_tick) begin
        auto_pend <= 1'b0;
        if (sync2 == debounced) db_cnt <= '0;
        else if (db_cnt == DEB_LAST) begin
          debounced <= sync2;
          db_cnt    <= '0;
        end else db_cnt <= db_cnt + 1'b1;
      end
    end

  assign launch   = (state == S_IDLE) && ((debounced && !deb_q) || (i2c_tick && auto_pend));
  assign issue_ok = (state == S_ISSUE) && !i2c_ready;
  assign timeout  = (state == S_ISSUE) && i2c_ready && i2c_tick && (to_cnt == TO_LAST);
  assign cmd_fin  = (state == S_WAIT) && i2c_ready;
  assign last     = (cmd_index == IDX_LAST);
  assign gap_end  = (state == S_GAP) && i2c_tick && (gap_cnt == GAP_LAST);
  assign next_cmd = (cmd_fin && !last && GAP_TICKS == 0) || gap_end;
  assign ld_idx   = launch ? 4'd0 : cmd_index + 4'd1;
  assign ld_entry = CMD_TABLE[int'(ld_idx)*ENTRY_W +: ENTRY_W];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (launch) state_n = S_ISSUE;
      S_ISSUE: if (issue_ok) state_n = S_WAIT;
               else if (timeout) state_n = S_IDLE;
      S_WAIT:  if (cmd_fin) state_n = last ? S_IDLE : (GAP_TICKS == 0 ? S_ISSUE : S_GAP);
      S_GAP:   if (gap_end) state_n = S_ISSUE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    i2c_start = (state == S_ISSUE);
    busy      = (state != S_IDLE);
  end

  // fields load only when an entry is (re)issued, so they hold through WAIT and IDLE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cmd_index <= '0; done <= 1'b0; error <= 1'b0;
      to_cnt <= '0; gap_cnt <= '0;
      {i2c_addr, i2c_rw, i2c_packets, i2c_data} <= CMD_TABLE[ENTRY_W-1:0];
    end else begin
      if (launch) begin
        done  <= 1'b0;
        error <= 1'b0;
      end
      if (launch || next_cmd) begin
        cmd_index <= ld_idx;
        {i2c_addr, i2c_rw, i2c_packets, i2c_data} <= ld_entry;
        to_cnt <= '0;
      end else if (state == S_ISSUE && i2c_tick) to_cnt <= to_cnt + 1'b1;
      if (timeout) error <= 1'b1;
      if (cmd_fin && last) done <= 1'b1;
      if (state != S_GAP) gap_cnt <= '0;
      else if (i2c_tick)  gap_cnt <= gap_cnt + 1'b1;
    end
endmodule
